booth_seq_mult: RTL and testbench
=================================

Name: booth_seq_mult

Overview:
Parametrised multi-cycle signed (two's complement) multiplier using radix-2 Booth recoding. It generalises the fixed 8-bit combinational multiplier datapath to any operand width. One shared ripple adder is reused once per cycle instead of a full adder array. Valid/ready handshakes on both sides let it sit directly in a streaming datapath.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b are presented
in_ready  output  1  block can accept operands
a  input  WIDTH  signed multiplicand
b  input  WIDTH  signed multiplier
out_valid  output  1  product is valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  signed product a*b
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE; in_ready=1; out_valid=0; busy=0; product=0; all internal registers=0. Reset mid-RUN aborts the operation. No stale result is emitted after release.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge: latch a and b; acc=0 (WIDTH+1 bits, sign-extended); Q=b; q_1=0; count=WIDTH; go to RUN.
  - RUN (WIDTH cycles): in_ready=0. Each edge inspects {Q[0],q_1}:
    - 01: acc += sext(a)
    - 10: acc -= sext(a)
    - 00 or 11: no add
    - Then arithmetic right shift of {acc,Q,q_1} by 1, and count -= 1.
    - When count reaches 0, go to DONE and load product = {acc[WIDTH-1:0],Q}.
  - DONE: out_valid=1. product is held stable while out_valid & !out_ready. On out_valid&out_ready: out_valid=0, go to IDLE.
- Latency: acceptance at edge k gives out_valid=1 after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles with out_ready tied high.
- Arithmetic: the accumulator is WIDTH+1 bits, so -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2WIDTH-2) is exact with no overflow. Subtraction is done as acc + ~sext(a) + 1 using the carry-in.
- in_valid in RUN or DONE is ignored; the operands are not captured.
- a and b may change freely after acceptance; the latched copies are used.
- product is not cleared on leaving DONE. It retains the last result until the next DONE load. out_valid is the qualifier.
- No X on outputs after reset, for any input sequence.

Decomposition:
- Shared package booth_pkg:
  - state enum {IDLE, RUN, DONE} (2 bits)
  - localparam for count width = clog2(WIDTH+1)
  - WIDTH range-check constants
- Sub-module ripple_adder: parameter N (=WIDTH+1), ports x, y, cin, sum, cout. It is a chain of full-adder cells, purely combinational, and is instantiated once for the acc add/subtract.
- Elaboration error if WIDTH<2 or WIDTH>32.

Test Plan:
- WIDTH=8, out_ready=1, a=3, b=5 -> in_ready drops the cycle after accept; out_valid after exactly 8 cycles with product=16'h000F; back to IDLE next cycle.
- WIDTH=8, a=-128, b=-128 -> product=16'h4000 (+16384). Then a=-128, b=127 -> product=16'hC080 (-16256).
- WIDTH=8, a=0, b=-1 and a=-1, b=-1 -> product=16'h0000, then 16'h0001.
- Backpressure: out_ready=0 for 5 cycles after out_valid, a=-7, b=9 -> product holds 16'hFFC1 and out_valid stays 1. in_valid pulsed during RUN and DONE is not accepted (in_ready=0). out_ready=1 -> IDLE.
- Reset mid-RUN: assert rst_n=0 asynchronously at RUN cycle 3 -> outputs go to their reset values immediately. After release, a fresh a=2, b=-3 gives product=16'hFFFA.
- WIDTH=4 instance: exhaustive sweep of all 256 a,b pairs against a reference model, including -8*-8=8'h40. Random out_ready throttling throughout.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    // Controller states: waiting for operands, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Legal operand width range.
    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Bits needed to hold an iteration count from 0 up to w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/booth_seq_mult_ripple_adder.sv
// N-bit ripple-carry adder built from a chain of full-adder cells; combinational.
module ripple_adder #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/booth_seq_mult.sv
// Multi-cycle signed multiplier using radix-2 Booth recoding with one shared
// ripple adder and valid/ready handshakes on input and output.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned AW = WIDTH + 1;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("booth_seq_mult: WIDTH must be within 2..32");
    end

    state_e             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [AW-1:0]      m_sext;
    logic [AW-1:0]      add_y;
    logic               add_cin;
    logic [AW-1:0]      add_sum;
    logic               add_cout_unused;

    assign m_sext = {m_q[WIDTH-1], m_q};

    ripple_adder #(
        .N (AW)
    ) u_adder (
        .x    (acc_q),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout_unused)
    );

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // Next-state logic: operand capture, one Booth step per RUN cycle, result hand-off.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        add_y   = '0;
        add_cin = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    acc_d   = '0;
                    q_d     = b;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                // Subtraction reuses the adder as acc + ~m + 1 via the carry-in.
                case ({q_q[0], q1_q})
                    2'b01: add_y = m_sext;
                    2'b10: begin
                        add_y   = ~m_sext;
                        add_cin = 1'b1;
                    end
                    default: ;
                endcase
                acc_d = {add_sum[AW-1], add_sum[AW-1:1]};
                q_d   = {add_sum[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    prod_d  = {acc_d[WIDTH-1:0], q_d};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult at WIDTH=8 and WIDTH=4.
module tb_booth_seq_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] product8;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, busy4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  product4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8)
    );

    booth_seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .product(product4), .busy(busy4)
    );

    // Reference: plain signed integer multiplication truncated to 2*W bits.
    function automatic logic [15:0] ref8(input int x, input int y);
        int p;
        p = x * y;
        return p[15:0];
    endfunction

    function automatic logic [7:0] ref4(input int x, input int y);
        int p;
        p = x * y;
        return p[7:0];
    endfunction

    // Drives one WIDTH=8 operation with out_ready high; returns result and latency.
    task automatic run8(input int x, input int y, output logic [15:0] p,
                        output int lat, output bit ok);
        @(negedge clk);
        a8 = x[7:0];
        b8 = y[7:0];
        in_valid8 = 1'b1;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = (out_valid8 === 1'b1);
        p = product8;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || product8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset8: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 0000",
                     in_ready8, out_valid8, busy8, product8);
        end
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0 || product4 !== 8'h00) begin
            errors++;
            $display("FAIL reset4: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 00",
                     in_ready4, out_valid4, busy4, product4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        @(negedge clk);
        a8 = 8'd3;
        b8 = 8'd5;
        in_valid8 = 1'b1;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        checks++;
        if (in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL accept: in_ready=%b busy=%b, want 0 1", in_ready8, busy8);
        end
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL latency: got %0d cycles, want 8", lat);
        end
        checks++;
        if (product8 !== 16'h000F) begin
            errors++;
            $display("FAIL basic_product: got %h, want 000f", product8);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     in_ready8, out_valid8, busy8);
        end
    endtask

    task automatic test_corners;
        int xs [4] = '{-128, -128, 0, -1};
        int ys [4] = '{-128, 127, -1, -1};
        logic [15:0] want [4] = '{16'h4000, 16'hC080, 16'h0000, 16'h0001};
        logic [15:0] p;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            run8(xs[i], ys[i], p, lat, ok);
            checks++;
            if (!ok || p !== want[i] || p !== ref8(xs[i], ys[i])) begin
                errors++;
                $display("FAIL corner %0d*%0d: got %h valid=%b, want %h", xs[i], ys[i], p, ok, want[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        @(negedge clk);
        a8 = 8'hF9;
        b8 = 8'd9;
        in_valid8 = 1'b1;
        out_ready8 = 1'b0;
        @(posedge clk);
        #1;
        // Keep offering different operands through RUN and DONE.
        a8 = 8'd55;
        b8 = 8'd66;
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 50) begin
            checks++;
            if (in_ready8 !== 1'b0) begin
                errors++;
                $display("FAIL run_in_ready: got %b, want 0", in_ready8);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid8 !== 1'b1 || product8 !== 16'hFFC1 || in_ready8 !== 1'b0) begin
                errors++;
                $display("FAIL stall %0d: out_valid=%b product=%h in_ready=%b, want 1 ffc1 0",
                         i, out_valid8, product8, in_ready8);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready8, out_valid8);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b0 || product8 !== 16'hFFC1) begin
            errors++;
            $display("FAIL bp_no_capture: busy=%b product=%h, want 0 ffc1", busy8, product8);
        end
    endtask

    task automatic test_reset_midrun;
        logic [15:0] p;
        int lat;
        bit ok;
        @(negedge clk);
        a8 = 8'd100;
        b8 = 8'd77;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || product8 !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 0000",
                     in_ready8, out_valid8, busy8, product8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL stale %0d: out_valid=%b busy=%b, want 0 0", i, out_valid8, busy8);
            end
        end
        run8(2, -3, p, lat, ok);
        checks++;
        if (!ok || p !== 16'hFFFA) begin
            errors++;
            $display("FAIL after_reset: got %h valid=%b, want fffa", p, ok);
        end
    endtask

    task automatic test_w4_sweep;
        logic [7:0] got;
        logic [7:0] want;
        bit done;
        int sa, sb, n;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                sa = (i < 8) ? i : i - 16;
                sb = (j < 8) ? j : j - 16;
                want = ref4(sa, sb);
                @(negedge clk);
                a4 = 4'(i);
                b4 = 4'(j);
                in_valid4 = 1'b1;
                @(posedge clk);
                #1;
                in_valid4 = 1'b0;
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                done = 1'b0;
                got = '0;
                n = 0;
                while (!done && n < 100) begin
                    @(negedge clk);
                    out_ready4 = 1'($urandom_range(0, 1));
                    if (out_valid4 === 1'b1 && out_ready4) begin
                        got = product4;
                        done = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                    n++;
                end
                checks++;
                if (!done || got !== want) begin
                    errors++;
                    $display("FAIL w4 %0d*%0d: got %h done=%b, want %h", sa, sb, got, done, want);
                end
                if (sa == -8 && sb == -8) begin
                    checks++;
                    if (got !== 8'h40) begin
                        errors++;
                        $display("FAIL w4_minmin: got %h, want 40", got);
                    end
                end
            end
        end
        out_ready4 = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_corners;
        test_backpressure;
        test_reset_midrun;
        test_w4_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
